// File: rtl/mmss_countdown.sv
// MM:SS BCD countdown timer with run-control FSM and a tick-counted alarm window.
// Digits decrement once per tick enable in RUN; reaching 00:00 pulses expired and enters ALARM.
module mmss_countdown #(
   parameter int ALARM_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       clear,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] set_m10,
   input  logic [3:0] set_m1,
   input  logic [3:0] set_s10,
   input  logic [3:0] set_s1,
   output logic [3:0] m10,
   output logic [3:0] m1,
   output logic [3:0] s10,
   output logic [3:0] s1,
   output logic       running,
   output logic       expired,
   output logic       alarm
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] ALARM = 2'd3;

   localparam logic [3:0] LAST_TICK = 4'(ALARM_TICKS - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  alarm_cnt_q, alarm_cnt_d;
   logic        expired_q, expired_d;
   logic        running_q, alarm_q;

   function automatic logic [3:0] sat_ones(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   function automatic logic [3:0] sat_tens(input logic [3:0] v);
      return (v > 4'd5) ? 4'd5 : v;
   endfunction

   // Borrow ripples s1 -> s10 -> m1 -> m10; never called at 00:00.
   function automatic logic [15:0] dec_mmss(input logic [15:0] c);
      logic [3:0] dm10, dm1, ds10, ds1;
      {dm10, dm1, ds10, ds1} = c;
      if (ds1 != 4'd0) begin
         ds1 = ds1 - 4'd1;
      end else begin
         ds1 = 4'd9;
         if (ds10 != 4'd0) begin
            ds10 = ds10 - 4'd1;
         end else begin
            ds10 = 4'd5;
            if (dm1 != 4'd0) begin
               dm1 = dm1 - 4'd1;
            end else begin
               dm1  = 4'd9;
               dm10 = dm10 - 4'd1;
            end
         end
      end
      return {dm10, dm1, ds10, ds1};
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alarm_cnt_d = alarm_cnt_q;
      expired_d   = 1'b0;
      if (clear) begin
         state_d     = IDLE;
         cnt_d       = 16'h0000;
         alarm_cnt_d = 4'd0;
      end else if (load && (state_q != RUN)) begin
         cnt_d = {sat_tens(set_m10), sat_ones(set_m1), sat_tens(set_s10), sat_ones(set_s1)};
         if (state_q == ALARM) begin
            state_d     = IDLE;
            alarm_cnt_d = 4'd0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (cnt_q != 16'h0000)) state_d = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  cnt_d = dec_mmss(cnt_q);
                  if (cnt_q == 16'h0001) begin
                     state_d     = ALARM;
                     expired_d   = 1'b1;
                     alarm_cnt_d = 4'd0;
                  end
               end
            end
            PAUSE: begin
               if (start && !pause) state_d = RUN;
            end
            default: begin
               if (tick) begin
                  if (alarm_cnt_q == LAST_TICK) begin
                     state_d     = IDLE;
                     alarm_cnt_d = 4'd0;
                  end else begin
                     alarm_cnt_d = alarm_cnt_q + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 16'h0000;
         alarm_cnt_q <= 4'd0;
         expired_q   <= 1'b0;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alarm_cnt_q <= alarm_cnt_d;
         expired_q   <= expired_d;
         running_q   <= (state_d == RUN);
         alarm_q     <= (state_d == ALARM);
      end
   end

   assign {m10, m1, s10, s1} = cnt_q;
   assign running = running_q;
   assign expired = expired_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_mmss_countdown.sv
// Directed bench for mmss_countdown: per-scenario tasks with hand-computed expectations.
module tb_mmss_countdown;

   logic       clk = 1'b0;
   logic       rst, tick, clear, load, start, pause;
   logic [3:0] set_m10, set_m1, set_s10, set_s1;
   logic [3:0] m10, m1, s10, s1;
   logic       running, expired, alarm;
   logic [15:0] digits;
   int checks = 0;
   int errors = 0;

   mmss_countdown #(.ALARM_TICKS(3)) dut (
      .clk(clk), .rst(rst), .tick(tick), .clear(clear), .load(load),
      .start(start), .pause(pause),
      .set_m10(set_m10), .set_m1(set_m1), .set_s10(set_s10), .set_s1(set_s1),
      .m10(m10), .m1(m1), .s10(s10), .s1(s1),
      .running(running), .expired(expired), .alarm(alarm)
   );

   always #5 clk = ~clk;
   assign digits = {m10, m1, s10, s1};

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      {set_m10, set_m1, set_s10, set_s1} = v;
      load = 1'b1; step(); load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1; step(); tick = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); rst = 1'b0;
      checks++;
      if (digits !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 || alarm !== 1'b0) begin
         errors++;
         $display("FAIL reset: digits=%h run=%b exp=%b alarm=%b, required 0000 0 0 0", digits, running, expired, alarm);
      end
   endtask

   task automatic test_borrow_chain();
      do_load(16'h1000);
      checks++;
      if (digits !== 16'h1000) begin errors++; $display("FAIL borrow_load: got %h required 1000", digits); end
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL borrow_start: running=%b required 1", running); end
      do_tick();
      checks++;
      if (digits !== 16'h0959 || running !== 1'b1 || expired !== 1'b0) begin
         errors++;
         $display("FAIL borrow_tick: digits=%h run=%b exp=%b required 0959 1 0", digits, running, expired);
      end
      do_clear();
   endtask

   task automatic test_expiry();
      do_load(16'h0002);
      do_start();
      do_tick();
      checks++;
      if (digits !== 16'h0001 || expired !== 1'b0) begin
         errors++; $display("FAIL expiry_first: digits=%h exp=%b required 0001 0", digits, expired);
      end
      do_tick();
      checks++;
      if (digits !== 16'h0000 || expired !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL expiry_hit: digits=%h exp=%b alarm=%b run=%b required 0000 1 1 0", digits, expired, alarm, running);
      end
      do_start();
      checks++;
      if (expired !== 1'b0 || alarm !== 1'b1 || running !== 1'b0) begin
         errors++; $display("FAIL expiry_pulse_start: exp=%b alarm=%b run=%b required 0 1 0", expired, alarm, running);
      end
      do_tick();
      do_tick();
      checks++;
      if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold: alarm=%b required 1", alarm); end
      do_tick();
      checks++;
      if (alarm !== 1'b0 || running !== 1'b0 || expired !== 1'b0) begin
         errors++; $display("FAIL alarm_end: alarm=%b run=%b exp=%b required 0 0 0", alarm, running, expired);
      end
   endtask

   task automatic test_tick_held();
      do_load(16'h0003);
      do_start();
      tick = 1'b1;
      step();
      checks++;
      if (digits !== 16'h0002) begin errors++; $display("FAIL held_tick1: got %h required 0002", digits); end
      step();
      tick = 1'b0;
      checks++;
      if (digits !== 16'h0001) begin errors++; $display("FAIL held_tick2: got %h required 0001", digits); end
      do_clear();
   endtask

   task automatic test_load_saturation();
      do_load(16'h7F6A);
      checks++;
      if (digits !== 16'h5959) begin errors++; $display("FAIL sat_load: got %h required 5959", digits); end
      do_start();
      do_tick();
      checks++;
      if (digits !== 16'h5958) begin errors++; $display("FAIL sat_tick: got %h required 5958", digits); end
      do_clear();
   endtask

   task automatic test_pause_resume();
      do_load(16'h0030);
      do_start();
      pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
      checks++;
      if (digits !== 16'h0030 || running !== 1'b0) begin
         errors++; $display("FAIL pause_wins: digits=%h run=%b required 0030 0", digits, running);
      end
      for (int i = 0; i < 5; i++) do_tick();
      checks++;
      if (digits !== 16'h0030) begin errors++; $display("FAIL pause_ticks: got %h required 0030", digits); end
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL resume: running=%b required 1", running); end
      do_load(16'h0100);
      checks++;
      if (digits !== 16'h0030 || running !== 1'b1) begin
         errors++; $display("FAIL run_load_ignored: digits=%h run=%b required 0030 1", digits, running);
      end
      do_tick();
      checks++;
      if (digits !== 16'h0029) begin errors++; $display("FAIL resume_tick: got %h required 0029", digits); end
      pause = 1'b1; step(); pause = 1'b0;
      do_load(16'h0045);
      checks++;
      if (digits !== 16'h0045 || running !== 1'b0) begin
         errors++; $display("FAIL pause_load: digits=%h run=%b required 0045 0", digits, running);
      end
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL pause_load_resume: running=%b required 1", running); end
      do_clear();
   endtask

   task automatic test_zero_start();
      rst = 1'b1; step(); rst = 1'b0;
      do_start();
      checks++;
      if (running !== 1'b0 || expired !== 1'b0 || alarm !== 1'b0) begin
         errors++; $display("FAIL zero_start: run=%b exp=%b alarm=%b required 0 0 0", running, expired, alarm);
      end
      do_tick();
      checks++;
      if (digits !== 16'h0000 || expired !== 1'b0) begin
         errors++; $display("FAIL zero_tick: digits=%h exp=%b required 0000 0", digits, expired);
      end
      do_load(16'h0005);
      do_start();
      pause = 1'b1; step(); pause = 1'b0;
      start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL start_pause_together: running=%b required 0", running); end
      do_tick();
      checks++;
      if (digits !== 16'h0005) begin errors++; $display("FAIL paused_no_dec: got %h required 0005", digits); end
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL pause_resume2: running=%b required 1", running); end
      do_clear();
   endtask

   task automatic test_reset_mid_run();
      do_load(16'h1234);
      do_start();
      rst = 1'b1; tick = 1'b1; step(); rst = 1'b0; tick = 1'b0;
      checks++;
      if (digits !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_run: digits=%h run=%b alarm=%b exp=%b required 0000 0 0 0", digits, running, alarm, expired);
      end
      do_load(16'h1234);
      do_start();
      clear = 1'b1; tick = 1'b1; step(); clear = 1'b0; tick = 1'b0;
      checks++;
      if (digits !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL clear_mid_run: digits=%h run=%b alarm=%b exp=%b required 0000 0 0 0", digits, running, alarm, expired);
      end
   endtask

   task automatic test_alarm_exit();
      do_load(16'h0001);
      do_start();
      do_tick();
      do_clear();
      checks++;
      if (alarm !== 1'b0 || digits !== 16'h0000) begin
         errors++; $display("FAIL clear_alarm: alarm=%b digits=%h required 0 0000", alarm, digits);
      end
      do_load(16'h0001);
      do_start();
      do_tick();
      do_load(16'h0200);
      checks++;
      if (alarm !== 1'b0 || digits !== 16'h0200 || running !== 1'b0) begin
         errors++; $display("FAIL load_alarm: alarm=%b digits=%h run=%b required 0 0200 0", alarm, digits, running);
      end
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL load_alarm_idle: running=%b required 1", running); end
      do_clear();
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      set_m10 = 4'd0; set_m1 = 4'd0; set_s10 = 4'd0; set_s1 = 4'd0;
      test_reset();
      test_borrow_chain();
      test_expiry();
      test_tick_held();
      test_load_saturation();
      test_pause_resume();
      test_zero_start();
      test_reset_mid_run();
      test_alarm_exit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
